// File: rtl/shift_pkg.sv
// Shared types and saturation limits for the register-shift sequencer.
// Used by shift_step_unit and shift_seq_ctrl.
package shift_pkg;

  typedef enum logic [1:0] {
    SH_LSL,
    SH_LSR,
    SH_ASR,
    SH_ROR
  } sh_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } seq_state_t;

  localparam logic [8:0] SAT_LSX = 9'd33;
  localparam logic [8:0] SAT_ASR = 9'd32;

  // Amounts past the saturation point give the same result and carry.
  function automatic logic [8:0] eff_amt(
    input sh_t        sh,
    input logic [7:0] amt
  );
    logic [8:0] a9;
    a9 = {1'b0, amt};
    eff_amt = a9;
    unique case (sh)
      SH_LSL, SH_LSR:
        eff_amt = (a9 > SAT_LSX) ? SAT_LSX : a9;
      SH_ASR:
        eff_amt = (a9 > SAT_ASR) ? SAT_ASR : a9;
      SH_ROR:
        eff_amt = {4'b0, amt[4:0]};
      default:
        eff_amt = a9;
    endcase
  endfunction

endpackage

// File: rtl/shift_step_unit.sv
// Single-step combinational shifter: shifts v by k (0..31) bits.
// k=0 passes v and the incoming carry through unchanged.
module shift_step_unit
  import shift_pkg::*;
(
  input  logic [31:0] v,
  input  sh_t         sh,
  input  logic [4:0]  k,
  input  logic        cin,
  output logic [31:0] v_next,
  output logic        carry_out
);

  logic [4:0] k_neg;
  logic [4:0] k_m1;

  assign k_neg = 5'd0 - k;
  assign k_m1  = k - 5'd1;

  always_comb begin
    v_next    = v;
    carry_out = cin;
    if (k != 5'd0) begin
      unique case (sh)
        SH_LSL: begin
          v_next    = v << k;
          carry_out = v[k_neg];
        end
        SH_LSR: begin
          v_next    = v >> k;
          carry_out = v[k_m1];
        end
        SH_ASR: begin
          v_next    = $signed(v) >>> k;
          carry_out = v[k_m1];
        end
        SH_ROR: begin
          v_next    = (v >> k) | (v << k_neg);
          carry_out = v_next[31];
        end
        default: begin
          v_next    = v;
          carry_out = cin;
        end
      endcase
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle sequencer for ARM register-controlled shifts, STEP_MAX bits per cycle.
// Optional RRX request port enabled by defining SHIFT_SEQ_RRX_EN.
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int unsigned STEP_MAX = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [1:0]  req_sh,
  input  logic [7:0]  req_amt,
  input  logic        req_cin,
`ifdef SHIFT_SEQ_RRX_EN
  input  logic        req_rrx,
`endif
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_carry
);

  localparam logic [8:0] STEP_W = 9'(STEP_MAX);
  localparam logic [4:0] STEP_K = 5'(STEP_MAX);

  seq_state_t  state_q, state_d;
  sh_t         sh_q, sh_d;
  logic [8:0]  rem_q, rem_d;
  logic [31:0] v_q, v_d;
  logic        c_q, c_d;

  sh_t         req_sh_t;
  logic [8:0]  eff;
  logic        ror32;
  logic        is_rrx;
  logic [4:0]  k;
  logic [31:0] step_v;
  logic        step_c;

  assign req_sh_t = sh_t'(req_sh);
  assign eff      = eff_amt(req_sh_t, req_amt);
  assign ror32    = (req_sh_t == SH_ROR) &&
                    (req_amt != 8'd0) &&
                    (req_amt[4:0] == 5'd0);
`ifdef SHIFT_SEQ_RRX_EN
  assign is_rrx   = (req_sh_t == SH_ROR) && req_rrx;
`else
  assign is_rrx   = 1'b0;
`endif

  assign k = (rem_q < STEP_W) ? rem_q[4:0] : STEP_K;

  shift_step_unit u_step (
    .v         (v_q),
    .sh        (sh_q),
    .k         (k),
    .cin       (c_q),
    .v_next    (step_v),
    .carry_out (step_c)
  );

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    rem_d   = rem_q;
    v_d     = v_q;
    c_d     = c_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          sh_d  = req_sh_t;
          v_d   = req_a;
          c_d   = req_cin;
          rem_d = eff;
          if (is_rrx) begin
            v_d     = {req_cin, req_a[31:1]};
            c_d     = req_a[0];
            state_d = S_DONE;
          end else if (ror32) begin
            c_d     = req_a[31];
            state_d = S_DONE;
          end else if (eff == 9'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        v_d   = step_v;
        c_d   = step_c;
        rem_d = rem_q - {4'b0, k};
        if (rem_d == 9'd0) state_d = S_DONE;
      end
      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sh_q    <= SH_LSL;
      rem_q   <= 9'd0;
      v_q     <= 32'd0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      rem_q   <= rem_d;
      v_q     <= v_d;
      c_q     <= c_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_DONE);
  assign rsp_result = v_q;
  assign rsp_carry  = c_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl at STEP_MAX 31, 8 and 1.
// Build with SHIFT_SEQ_RRX_EN defined to cover the RRX request.
module tb_shift_seq_ctrl;

  logic        clk;
  logic        reset;
  logic [2:0]  req_valid_w;
  logic [2:0]  rdy_w;
  logic [31:0] req_a;
  logic [1:0]  req_sh;
  logic [7:0]  req_amt;
  logic        req_cin;
`ifdef SHIFT_SEQ_RRX_EN
  logic        req_rrx;
`endif
  logic [2:0]  vld_w;
  logic        rsp_ready;
  logic [31:0] res_w [3];
  logic [2:0]  car_w;

  int vectors;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  shift_seq_ctrl #(.STEP_MAX(31)) u_dut31 (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid_w[0]),
    .req_ready  (rdy_w[0]),
    .req_a      (req_a),
    .req_sh     (req_sh),
    .req_amt    (req_amt),
    .req_cin    (req_cin),
`ifdef SHIFT_SEQ_RRX_EN
    .req_rrx    (req_rrx),
`endif
    .rsp_valid  (vld_w[0]),
    .rsp_ready  (rsp_ready),
    .rsp_result (res_w[0]),
    .rsp_carry  (car_w[0])
  );

  shift_seq_ctrl #(.STEP_MAX(8)) u_dut8 (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid_w[1]),
    .req_ready  (rdy_w[1]),
    .req_a      (req_a),
    .req_sh     (req_sh),
    .req_amt    (req_amt),
    .req_cin    (req_cin),
`ifdef SHIFT_SEQ_RRX_EN
    .req_rrx    (req_rrx),
`endif
    .rsp_valid  (vld_w[1]),
    .rsp_ready  (rsp_ready),
    .rsp_result (res_w[1]),
    .rsp_carry  (car_w[1])
  );

  shift_seq_ctrl #(.STEP_MAX(1)) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid_w[2]),
    .req_ready  (rdy_w[2]),
    .req_a      (req_a),
    .req_sh     (req_sh),
    .req_amt    (req_amt),
    .req_cin    (req_cin),
`ifdef SHIFT_SEQ_RRX_EN
    .req_rrx    (req_rrx),
`endif
    .rsp_valid  (vld_w[2]),
    .rsp_ready  (rsp_ready),
    .rsp_result (res_w[2]),
    .rsp_carry  (car_w[2])
  );

  // Latency counts posedges from the accept edge (inclusive) to rsp_valid.
  task automatic issue(
    input  int          sel,
    input  logic [31:0] a,
    input  logic [1:0]  sh,
    input  logic [7:0]  amt,
    input  logic        cin,
    input  logic        rrx,
    output int          lat,
    output logic [31:0] res,
    output logic        car
  );
    req_a   = a;
    req_sh  = sh;
    req_amt = amt;
    req_cin = cin;
`ifdef SHIFT_SEQ_RRX_EN
    req_rrx = rrx;
`else
    if (rrx) $display("note: rrx ignored in this build");
`endif
    req_valid_w[sel] = 1'b1;
    @(posedge clk); #1;
    req_valid_w[sel] = 1'b0;
`ifdef SHIFT_SEQ_RRX_EN
    req_rrx = 1'b0;
`endif
    lat = 1;
    while (!vld_w[sel] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = res_w[sel];
    car = car_w[sel];
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (vld_w[i] !== 1'b0 || rdy_w[i] !== 1'b1 ||
          res_w[i] !== 32'd0 || car_w[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset dut%0d: vld=%b rdy=%b res=%h c=%b, want 0 1 0 0",
                 i, vld_w[i], rdy_w[i], res_w[i], car_w[i]);
      end
    end
  endtask

  task automatic test_lsl();
    int lat; logic [31:0] r; logic c;
    issue(0, 32'h0000_0001, 2'b00, 8'd4, 1'b0, 1'b0, lat, r, c);
    vectors++;
    if (r !== 32'h10 || c !== 1'b0 || lat !== 2) begin
      errors++;
      $display("FAIL lsl4: res=%h c=%b lat=%0d, want 00000010 0 2", r, c, lat);
    end
    issue(0, 32'h8000_0001, 2'b00, 8'd32, 1'b0, 1'b0, lat, r, c);
    vectors++;
    if (r !== 32'h0 || c !== 1'b1 || lat !== 3) begin
      errors++;
      $display("FAIL lsl32: res=%h c=%b lat=%0d, want 0 1 3", r, c, lat);
    end
  endtask

  task automatic test_lsr();
    int lat; logic [31:0] r; logic c;
    issue(0, 32'h8000_0001, 2'b01, 8'd32, 1'b0, 1'b0, lat, r, c);
    vectors++;
    if (r !== 32'h0 || c !== 1'b1 || lat !== 3) begin
      errors++;
      $display("FAIL lsr32: res=%h c=%b lat=%0d, want 0 1 3", r, c, lat);
    end
    issue(0, 32'h8000_0001, 2'b01, 8'd40, 1'b1, 1'b0, lat, r, c);
    vectors++;
    if (r !== 32'h0 || c !== 1'b0 || lat !== 3) begin
      errors++;
      $display("FAIL lsr40: res=%h c=%b lat=%0d, want 0 0 3", r, c, lat);
    end
  endtask

  task automatic test_asr();
    int lat; logic [31:0] r; logic c;
    issue(0, 32'h8000_0000, 2'b10, 8'd200, 1'b0, 1'b0, lat, r, c);
    vectors++;
    if (r !== 32'hFFFF_FFFF || c !== 1'b1 || lat !== 3) begin
      errors++;
      $display("FAIL asr200: res=%h c=%b lat=%0d, want ffffffff 1 3", r, c, lat);
    end
    issue(1, 32'h8000_0000, 2'b10, 8'd20, 1'b1, 1'b0, lat, r, c);
    vectors++;
    if (r !== 32'hFFFF_F800 || c !== 1'b0 || lat !== 4) begin
      errors++;
      $display("FAIL asr20_s8: res=%h c=%b lat=%0d, want fffff800 0 4", r, c, lat);
    end
  endtask

  task automatic test_ror();
    int lat; logic [31:0] r; logic c;
    issue(0, 32'h0000_00F1, 2'b11, 8'd36, 1'b1, 1'b0, lat, r, c);
    vectors++;
    if (r !== 32'h1000_000F || c !== 1'b0 || lat !== 2) begin
      errors++;
      $display("FAIL ror36: res=%h c=%b lat=%0d, want 1000000f 0 2", r, c, lat);
    end
    issue(0, 32'h0000_00F1, 2'b11, 8'd32, 1'b1, 1'b0, lat, r, c);
    vectors++;
    if (r !== 32'h0000_00F1 || c !== 1'b0 || lat !== 1) begin
      errors++;
      $display("FAIL ror32: res=%h c=%b lat=%0d, want 000000f1 0 1", r, c, lat);
    end
    issue(0, 32'h8000_0000, 2'b11, 8'd0, 1'b0, 1'b0, lat, r, c);
    vectors++;
    if (r !== 32'h8000_0000 || c !== 1'b0 || lat !== 1) begin
      errors++;
      $display("FAIL ror0: res=%h c=%b lat=%0d, want 80000000 0 1", r, c, lat);
    end
  endtask

  task automatic test_hold();
    req_a   = 32'h1234_5678;
    req_sh  = 2'b00;
    req_amt = 8'd0;
    req_cin = 1'b1;
    req_valid_w[0] = 1'b1;
    @(posedge clk); #1;
    req_a   = 32'hDEAD_BEEF;
    req_amt = 8'd3;
    req_cin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (vld_w[0] !== 1'b1 || rdy_w[0] !== 1'b0 ||
          res_w[0] !== 32'h1234_5678 || car_w[0] !== 1'b1) begin
        errors++;
        $display("FAIL hold%0d: vld=%b rdy=%b res=%h c=%b, want 1 0 12345678 1",
                 i, vld_w[0], rdy_w[0], res_w[0], car_w[0]);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    vectors++;
    if (vld_w[0] !== 1'b0 || rdy_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL bubble: vld=%b rdy=%b, want 0 1", vld_w[0], rdy_w[0]);
    end
    req_valid_w[0] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    req_a   = 32'h0000_0001;
    req_sh  = 2'b00;
    req_amt = 8'd20;
    req_cin = 1'b0;
    vectors++;
    if (rdy_w[2] !== 1'b1) begin
      errors++;
      $display("FAIL s1_ready: rdy=%b, want 1", rdy_w[2]);
    end
    req_valid_w[2] = 1'b1;
    @(posedge clk); #1;
    req_valid_w[2] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (rdy_w[2] !== 1'b0 || vld_w[2] !== 1'b0) begin
      errors++;
      $display("FAIL s1_busy: rdy=%b vld=%b, want 0 0", rdy_w[2], vld_w[2]);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vectors++;
    if (vld_w[2] !== 1'b0 || rdy_w[2] !== 1'b1 ||
        res_w[2] !== 32'd0 || car_w[2] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: vld=%b rdy=%b res=%h c=%b, want 0 1 0 0",
               vld_w[2], rdy_w[2], res_w[2], car_w[2]);
    end
    repeat (25) @(posedge clk);
    #1;
    vectors++;
    if (vld_w[2] !== 1'b0 || rdy_w[2] !== 1'b1) begin
      errors++;
      $display("FAIL discarded: vld=%b rdy=%b, want 0 1", vld_w[2], rdy_w[2]);
    end
  endtask

`ifdef SHIFT_SEQ_RRX_EN
  task automatic test_rrx();
    int lat; logic [31:0] r; logic c;
    issue(0, 32'h0000_0003, 2'b11, 8'd9, 1'b1, 1'b1, lat, r, c);
    vectors++;
    if (r !== 32'h8000_0001 || c !== 1'b1 || lat !== 1) begin
      errors++;
      $display("FAIL rrx: res=%h c=%b lat=%0d, want 80000001 1 1", r, c, lat);
    end
  endtask
`endif

  initial begin
    vectors     = 0;
    errors      = 0;
    reset       = 1'b1;
    req_valid_w = 3'b000;
    rsp_ready   = 1'b0;
    req_a       = 32'd0;
    req_sh      = 2'b00;
    req_amt     = 8'd0;
    req_cin     = 1'b0;
`ifdef SHIFT_SEQ_RRX_EN
    req_rrx     = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_lsl();
    test_lsr();
    test_asr();
    test_ror();
    test_hold();
    test_mid_reset();
`ifdef SHIFT_SEQ_RRX_EN
    test_rrx();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
